hazard_fwd_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage core.
- Shadows the destination and source register fields of the instructions in EX, MEM and WB.
- Drives the select inputs of the 64-bit EX operand-forwarding muxes and the load-use stall to IF/ID.
- It is the control end of the operand mux interface: it decides which data source the datapath muxes pass through.

---
 rtl/hazard_fwd_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall and EX operand-forwarding control for the 5-stage core.
// Shadows rd/rs fields of EX, MEM and WB and drives the bypass mux selects.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush_ex,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic v;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic use1;
    logic use2;
    logic we;
    logic mr;
  } ex_t;

  typedef struct packed {
    logic v;
    reg_t rd;
    logic we;
    logic mr;
  } mem_t;

  typedef struct packed {
    logic v;
    reg_t rd;
    logic we;
  } wb_t;

  ex_t  ex_q, ex_d;
  mem_t mem_q;
  wb_t  wb_q;

  logic ld_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign ld_in_ex = ex_q.v && ex_q.mr && ex_q.we
                 && (ex_q.rd != '0);
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_q.rd);

  // flush wins: the dependent instruction is being killed anyway
  assign stall = id_valid && !flush_ex && ld_in_ex
              && (rs1_hit || rs2_hit);

  always_comb begin
    ex_d = '0;
    if (!(flush_ex || stall)) begin
      ex_d.v    = id_valid;
      ex_d.rd   = id_rd;
      ex_d.rs1  = id_rs1;
      ex_d.rs2  = id_rs2;
      ex_d.use1 = id_use_rs1;
      ex_d.use2 = id_use_rs2;
      ex_d.we   = id_reg_write;
      ex_d.mr   = id_mem_read;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic use_r,
    input reg_t rs,
    input mem_t m,
    input wb_t  w
  );
    logic ok;
    logic mem_hit;
    logic wb_hit;
    ok      = use_r && (rs != '0);
    mem_hit = ok && m.v && m.we && !m.mr
           && (m.rd == rs);
    wb_hit  = ok && w.v && w.we && (w.rd == rs);
    unique case (1'b1)
      mem_hit:            fwd_sel = 2'b01;
      wb_hit && !mem_hit: fwd_sel = 2'b10;
      default:            fwd_sel = 2'b00;
    endcase
  endfunction

  assign fwd_a_sel = fwd_sel(ex_q.use1, ex_q.rs1,
                             mem_q, wb_q);
  assign fwd_b_sel = fwd_sel(ex_q.use2, ex_q.rs2,
                             mem_q, wb_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q.v  <= ex_q.v;
      mem_q.rd <= ex_q.rd;
      mem_q.we <= ex_q.we;
      mem_q.mr <= ex_q.mr;
      wb_q.v   <= mem_q.v;
      wb_q.rd  <= mem_q.rd;
      wb_q.we  <= mem_q.we;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use stall,
// flush priority, counter saturation (narrow instance) and async reset.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush_ex;

  logic        stall;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_cnt;

  logic        stall_n;
  logic [1:0]  fwd_a_n;
  logic [1:0]  fwd_b_n;
  logic [3:0]  cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush_ex     (flush_ex),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt)
  );

  // narrow counter copy so saturation is reachable in a short run
  hazard_fwd_ctrl #(.CNT_W(4)) dut_n (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush_ex     (flush_ex),
    .stall        (stall_n),
    .fwd_a_sel    (fwd_a_n),
    .fwd_b_sel    (fwd_b_n),
    .stall_cnt    (cnt_n)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // apply one ID instruction for one cycle; returns at negedge+1
  task automatic issue(
    input bit       v,
    input bit [4:0] rs1,
    input bit [4:0] rs2,
    input bit       u1,
    input bit       u2,
    input bit [4:0] rd,
    input bit       we,
    input bit       mr,
    input bit       fl
  );
    @(negedge clk);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = we;
    id_mem_read  = mr;
    flush_ex     = fl;
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  task automatic chk_fwd(
    input string    tag,
    input bit [1:0] a,
    input bit [1:0] b
  );
    chk({tag, "_a"}, 32'(fwd_a_sel), 32'(a));
    chk({tag, "_b"}, 32'(fwd_b_sel), 32'(b));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (4) begin
      issue($urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom,
            $urandom);
      chk("rst_stall", 32'(stall), 0);
      chk_fwd("rst_fwd", 2'b00, 2'b00);
      chk("rst_cnt", 32'(stall_cnt), 0);
    end
    nop();
    rst_n = 1'b1;
    nop();
    chk("post_rst_stall", 32'(stall), 0);
    chk_fwd("post_rst_fwd", 2'b00, 2'b00);
    chk("post_rst_cnt", 32'(stall_cnt), 0);

    // add x5<-x1,x2 ; sub x6<-x5,x3
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
    issue(1, 5, 3, 1, 1, 6, 1, 0, 0);
    chk("exex_stall", 32'(stall), 0);
    nop();
    chk_fwd("exex", 2'b01, 2'b00);
    drain();

    // add x5 ; nop ; or x7<-x4,x5
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
    nop();
    issue(1, 4, 5, 1, 1, 7, 1, 0, 0);
    nop();
    chk_fwd("wbfwd", 2'b00, 2'b10);
    drain();

    // add x5 ; add x5 ; use x5,x5
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
    issue(1, 3, 4, 1, 1, 5, 1, 0, 0);
    issue(1, 5, 5, 1, 1, 10, 1, 0, 0);
    nop();
    chk_fwd("prio", 2'b01, 2'b01);
    drain();

    // ld x8 ; add x9<-x8,x8
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0);
    issue(1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("ldu_stall1", 32'(stall), 1);
    chk("ldu_cnt0", 32'(stall_cnt), 0);
    issue(1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("ldu_stall2", 32'(stall), 0);
    chk_fwd("ldu_bubble", 2'b00, 2'b00);
    chk("ldu_cnt1", 32'(stall_cnt), 1);
    nop();
    chk("ldu_stall3", 32'(stall), 0);
    chk_fwd("ldu_fwd", 2'b10, 2'b10);
    chk("ldu_cnt", 32'(stall_cnt), 1);
    chk("ldu_cnt_n", 32'(cnt_n), 1);
    drain();

    // ld x0 ; use x0
    issue(1, 1, 0, 1, 0, 0, 1, 1, 0);
    issue(1, 0, 0, 1, 1, 11, 1, 0, 0);
    chk("x0_stall", 32'(stall), 0);
    nop();
    chk_fwd("x0_fwd", 2'b00, 2'b00);
    drain();

    // ld x8 ; rs2=x8 but not used
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0);
    issue(1, 3, 8, 1, 0, 12, 1, 0, 0);
    chk("nouse_stall", 32'(stall), 0);
    drain();

    // ld x8 ; dependent add with flush in same cycle
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0);
    issue(1, 8, 8, 1, 1, 9, 1, 0, 1);
    chk("flush_stall", 32'(stall), 0);
    nop();
    chk_fwd("flush_bubble", 2'b00, 2'b00);
    chk("flush_cnt", 32'(stall_cnt), 1);
    drain();

    // ld x8<-x8 held: stalls every other cycle
    for (int i = 0; i < 80; i++) begin
      issue(1, 8, 0, 1, 0, 8, 1, 1, 0);
      chk("sat_stall", 32'(stall), 32'(i % 2));
    end
    nop();
    chk("cnt16", 32'(stall_cnt), 41);
    chk("cnt4_sat", 32'(cnt_n), 15);

    // async reset while a stall is active
    issue(1, 8, 0, 1, 0, 8, 1, 1, 0);
    issue(1, 8, 0, 1, 0, 8, 1, 1, 0);
    chk("pre_async_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("async_stall", 32'(stall), 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    chk_fwd("async_fwd", 2'b00, 2'b00);
    nop();
    rst_n = 1'b1;
    nop();
    chk("final_cnt", 32'(stall_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
